id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 59 +++++
 rtl/id_ex_stage_id_decode.sv | 66 ++++++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared types and constants for the ID/EX stage
package id_ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Decoder result; rt_src marks instructions that read rt as an operand.
    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [4:0] dst;
        logic       rt_src;
    } ctrl_t;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } idex_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

endpackage

// File: rtl/id_ex_stage_id_decode.sv
// rtl/id_ex_stage_id_decode.sv - combinational instruction decoder
// Ports: instr_i (IF/ID instruction word) -> ctrl_o (control bundle).
module id_decode
    import id_ex_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] unused_shamt;

    assign opcode       = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign rt           = instr_i[20:16];
    assign rd           = instr_i[15:11];
    assign unused_shamt = instr_i[10:6];

    always_comb begin
        ctrl_o = '0;
        case (opcode)
            OP_RTYPE: begin
                // Every R-type reads rt, even one whose funct is unsupported.
                ctrl_o.rt_src = 1'b1;
                case (funct)
                    FN_ADD: begin ctrl_o.alu_op = ALU_ADD; ctrl_o.reg_write = 1'b1; ctrl_o.dst = rd; end
                    FN_SUB: begin ctrl_o.alu_op = ALU_SUB; ctrl_o.reg_write = 1'b1; ctrl_o.dst = rd; end
                    FN_AND: begin ctrl_o.alu_op = ALU_AND; ctrl_o.reg_write = 1'b1; ctrl_o.dst = rd; end
                    FN_OR:  begin ctrl_o.alu_op = ALU_OR;  ctrl_o.reg_write = 1'b1; ctrl_o.dst = rd; end
                    FN_SLT: begin ctrl_o.alu_op = ALU_SLT; ctrl_o.reg_write = 1'b1; ctrl_o.dst = rd; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst       = rt;
            end
            OP_LW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst       = rt;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.rt_src    = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.alu_op = ALU_SUB;
                ctrl_o.branch = 1'b1;
                ctrl_o.rt_src = 1'b1;
            end
            default: ;
        endcase
        // Writes to $0 are architecturally discarded.
        if (ctrl_o.dst == 5'd0) begin
            ctrl_o.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode, operand bypass, load-use hazard FSM and ID/EX register
// Ports: clk, rst_n; IF/ID inputs id_valid/id_instr/id_pc; register file
// rf_a1/rf_a2 (addr out), rf_r1/rf_r2 (data in); write-through wb_en/wb_addr/
// wb_data; flush, ex_hold controls; id_stall out; registered ex_* fields out.
module id_ex_stage
    import id_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_r1,
    input  logic [31:0] rf_r2,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        ex_hold,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch
);

    state_e      state_q, state_d;
    idex_t       ex_q, ex_d;
    idex_t       dec;
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hazard;

    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rf_a1 = rs;
    assign rf_a2 = rt;

    id_decode u_id_decode (
        .instr_i (id_instr),
        .ctrl_o  (ctrl)
    );

    // $0 reads as zero; a same-cycle write to the read index wins over the
    // register file's stale data.
    assign rs_val = (rs == 5'd0) ? 32'd0 :
                    (wb_en && wb_addr == rs) ? wb_data : rf_r1;
    assign rt_val = (rt == 5'd0) ? 32'd0 :
                    (wb_en && wb_addr == rt) ? wb_data : rf_r2;

    // Masked in BUBBLE so the stalled instruction is released after one bubble.
    assign hazard = (state_q == ST_RUN) && id_valid && ex_q.valid && ex_q.mem_read &&
                    (ex_q.dst != 5'd0) &&
                    ((ex_q.dst == rs) || ((ex_q.dst == rt) && ctrl.rt_src));

    assign id_stall = rst_n && !flush && (ex_hold || hazard);

    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.pc        = id_pc;
        dec.rs_val    = rs_val;
        dec.rt_val    = rt_val;
        dec.imm       = {{16{id_instr[15]}}, id_instr[15:0]};
        dec.rs        = rs;
        dec.rt        = rt;
        dec.dst       = ctrl.dst;
        dec.alu_op    = ctrl.alu_op;
        dec.alu_src   = ctrl.alu_src;
        dec.reg_write = ctrl.reg_write;
        dec.mem_read  = ctrl.mem_read;
        dec.mem_write = ctrl.mem_write;
        dec.branch    = ctrl.branch;
    end

    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        if (flush) begin
            ex_d    = '0;
            state_d = ST_RUN;
        end else if (ex_hold) begin
            ex_d    = ex_q;
        end else if (hazard) begin
            ex_d    = '0;
            state_d = ST_BUBBLE;
        end else begin
            state_d = ST_RUN;
            ex_d    = id_valid ? dec : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs_val    = ex_q.rs_val;
    assign ex_rt_val    = ex_q.rt_val;
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_dst       = ex_q.dst;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_branch    = ex_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, wb_en, flush, ex_hold;
    logic [31:0] id_instr, id_pc, rf_r1, rf_r2, wb_data;
    logic [4:0]  wb_addr, rf_a1, rf_a2;
    logic        id_stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [3:0]  ex_alu_op;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_r1(rf_r1), .rf_r2(rf_r2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
    );

    // Expected EX contents; known/dst_known say which data fields are defined.
    typedef struct {
        bit          valid;
        bit [31:0]   pc, rs_val, rt_val, imm;
        bit [4:0]    rs, rt, dst;
        bit [3:0]    alu_op;
        bit          alu_src, reg_write, mem_read, mem_write, branch;
        bit          known, dst_known;
    } mex_t;

    mex_t m;
    bit   m_stalled_once;
    bit   last_stall;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] operand(input bit [4:0] idx, input bit [31:0] rf);
        if (idx == 0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf;
    endfunction

    function automatic mex_t bubble();
        mex_t b;
        b = '{default: 0};
        return b;
    endfunction

    // What an instruction in ID should look like one cycle later in EX.
    function automatic mex_t decode_now();
        mex_t r;
        bit [5:0] op, fn;
        r        = '{default: 0};
        op       = id_instr[31:26];
        fn       = id_instr[5:0];
        r.valid  = 1;
        r.known  = 1;
        r.pc     = id_pc;
        r.rs     = id_instr[25:21];
        r.rt     = id_instr[20:16];
        r.imm    = {{16{id_instr[15]}}, id_instr[15:0]};
        r.rs_val = operand(r.rs, rf_r1);
        r.rt_val = operand(r.rt, rf_r2);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
            r.alu_op    = (fn == 6'h20) ? 4'd0 : (fn == 6'h22) ? 4'd1 : (fn == 6'h24) ? 4'd2 :
                          (fn == 6'h25) ? 4'd3 : 4'd4;
            r.dst       = id_instr[15:11];
            r.reg_write = (r.dst != 0);
            r.dst_known = 1;
        end else if (op == 6'h08 || op == 6'h23) begin
            r.alu_src   = 1;
            r.mem_read  = (op == 6'h23);
            r.dst       = r.rt;
            r.reg_write = (r.dst != 0);
            r.dst_known = 1;
        end else if (op == 6'h2B) begin
            r.alu_src   = 1;
            r.mem_write = 1;
        end else if (op == 6'h04) begin
            r.alu_op = 4'd1;
            r.branch = 1;
        end
        return r;
    endfunction

    task automatic check_ex();
        chk("ex_valid", ex_valid, m.valid);
        chk("ex_alu_op", ex_alu_op, m.alu_op);
        chk("ex_alu_src", ex_alu_src, m.alu_src);
        chk("ex_reg_write", ex_reg_write, m.reg_write);
        chk("ex_mem_read", ex_mem_read, m.mem_read);
        chk("ex_mem_write", ex_mem_write, m.mem_write);
        chk("ex_branch", ex_branch, m.branch);
        if (m.known) begin
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_rs_val", ex_rs_val, m.rs_val);
            chk("ex_rt_val", ex_rt_val, m.rt_val);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_rs", ex_rs, m.rs);
            chk("ex_rt", ex_rt, m.rt);
        end
        if (m.dst_known) chk("ex_dst", ex_dst, m.dst);
    endtask

    // Check combinational outputs, advance the model, clock, check EX.
    task automatic tick();
        bit   uses_rt, hz, stall;
        mex_t nxt;
        #1;
        uses_rt = (id_instr[31:26] == 6'h00) || (id_instr[31:26] == 6'h2B) || (id_instr[31:26] == 6'h04);
        hz = id_valid && !m_stalled_once && m.valid && m.mem_read && m.dst != 0 &&
             (m.dst == id_instr[25:21] || (m.dst == id_instr[20:16] && uses_rt));
        stall = rst_n && !flush && (ex_hold || hz);
        chk("id_stall", id_stall, stall);
        chk("rf_a1", rf_a1, id_instr[25:21]);
        chk("rf_a2", rf_a2, id_instr[20:16]);
        nxt = m;
        if (!rst_n) begin
            nxt = bubble(); nxt.known = 1; nxt.dst_known = 1; m_stalled_once = 0;
        end else if (flush) begin
            nxt = bubble(); m_stalled_once = 0;
        end else if (ex_hold) begin
            nxt = m;
        end else if (hz) begin
            nxt = bubble(); m_stalled_once = 1;
        end else begin
            nxt = id_valid ? decode_now() : bubble();
            m_stalled_once = 0;
        end
        last_stall = stall;
        @(posedge clk);
        #1;
        m = nxt;
        check_ex();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int k;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        k   = $urandom_range(0, 11);
        if (k <= 4)  return {6'h00, rs, rt, rd, 5'd0, fns[k]};
        if (k == 5)  return {6'h08, rs, rt, imm};
        if (k <= 7)  return {6'h23, rs, rt, imm};
        if (k == 8)  return {6'h2B, rs, rt, imm};
        if (k == 9)  return {6'h04, rs, rt, imm};
        if (k == 10) return {6'h3F, rs, rt, imm};
        return {6'h00, rs, rt, rd, 5'd0, 6'h27};
    endfunction

    initial begin
        m = bubble(); m_stalled_once = 0; last_stall = 0;
        rst_n = 0; id_valid = 0; id_instr = 0; id_pc = 0; rf_r1 = 0; rf_r2 = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; ex_hold = 1;

        // Reset, with ex_hold high to show id_stall stays low during reset.
        tick(); tick();
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_pc", ex_pc, 32'd0);
        rst_n = 1; ex_hold = 0;

        // addi $2,$0,5
        id_valid = 1; id_instr = 32'h20020005; id_pc = 32'h100;
        tick();
        chk("addi_valid", ex_valid, 1'b1);
        chk("addi_dst", ex_dst, 5'd2);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_alu_src", ex_alu_src, 1'b1);
        chk("addi_reg_write", ex_reg_write, 1'b1);

        // Write-through bypass, then $0 stays zero despite a write to $0.
        id_instr = 32'h00623820; rf_r1 = 32'h1; wb_en = 1; wb_addr = 5'd3; wb_data = 32'hFFF0;
        tick();
        chk("bypass_rs_val", ex_rs_val, 32'hFFF0);
        id_instr = 32'h00023820; wb_addr = 5'd0; wb_data = 32'h1234;
        tick();
        chk("zero_rs_val", ex_rs_val, 32'd0);
        wb_en = 0;

        // lw $4,0($1) ; add $5,$4,$6
        id_instr = 32'h8C240000; tick();
        id_instr = 32'h00862820; tick();
        chk("lu_bubble", ex_valid, 1'b0);
        tick();
        chk("lu_add_valid", ex_valid, 1'b1);
        chk("lu_add_rs", ex_rs, 5'd4);

        // Flush in the hazard cycle.
        id_instr = 32'h8C240000; tick();
        id_instr = 32'h00862820; flush = 1; tick();
        chk("flush_bubble", ex_valid, 1'b0);
        flush = 0; tick();
        chk("flush_then_add", ex_valid, 1'b1);

        // ex_hold for three cycles.
        id_instr = 32'h20020005; tick();
        ex_hold = 1; id_instr = 32'h8C240000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_imm", ex_imm, 32'd5);
        end
        ex_hold = 0;

        // Undefined opcode, then add with rd = 0.
        id_instr = 32'hFC000000; tick();
        chk("undef_valid", ex_valid, 1'b1);
        chk("undef_reg_write", ex_reg_write, 1'b0);
        id_instr = 32'h00430020; tick();
        chk("rd0_reg_write", ex_reg_write, 1'b0);

        // Reset while in BUBBLE.
        id_instr = 32'h8C240000; tick();
        id_instr = 32'h00862820; tick();
        rst_n = 0; tick();
        chk("rst_bubble_valid", ex_valid, 1'b0);
        chk("rst_bubble_rs", ex_rs, 5'd0);
        rst_n = 1;

        // Randomized traffic; IF/ID holds while stalled.
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                id_instr = rand_instr();
                id_valid = ($urandom_range(0, 9) != 0);
                id_pc    = $urandom;
            end
            rf_r1   = $urandom;
            rf_r2   = $urandom;
            wb_en   = 1'($urandom);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            flush   = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 6) == 0);
            rst_n   = ($urandom_range(0, 59) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
